// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W    = 16;
    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BCNT_W         = 2;
    localparam int unsigned LEN_W          = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CKSUM  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loaderState_e;

    // States in which the loader consumes stream bytes.
    function automatic logic acceptsBytes(input loaderState_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CKSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the instruction-memory loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Stream source / memory side.
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles big-endian words from bytes; word/wordValid appear one cycle after the last byte.
module imem_word_packer
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byteValid,
    input  logic [BYTE_W-1:0] byteIn,
    output logic [DATA_W-1:0] word,
    output logic              wordValid,
    output logic              lastByte_c
);
    localparam int unsigned SHIFT_W  = DATA_W - BYTE_W;
    localparam int unsigned LAST_IDX = BYTES_PER_WORD - 1;

    logic [SHIFT_W-1:0] shiftQ;
    logic [DATA_W-1:0]  wordQ;
    logic [BCNT_W-1:0]  byteCntQ;
    logic               wordValidQ;

    assign lastByte_c = (byteCntQ == BCNT_W'(LAST_IDX));
    assign word       = wordQ;
    assign wordValid  = wordValidQ;

    // Shift bytes in at the LSB; latch the full word when the last byte lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftQ     <= '0;
            wordQ      <= '0;
            byteCntQ   <= '0;
            wordValidQ <= 1'b0;
        end else begin
            wordValidQ <= 1'b0;
            if (clear) begin
                shiftQ   <= '0;
                byteCntQ <= '0;
            end else if (byteValid) begin
                shiftQ   <= {shiftQ[SHIFT_W-BYTE_W-1:0], byteIn};
                byteCntQ <= byteCntQ + BCNT_W'(1);
                if (lastByte_c) begin
                    wordQ      <= {shiftQ, byteIn};
                    wordValidQ <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a framed byte stream and holds the CPU while loading.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W    = IMEM_ADDR_W,
    parameter int unsigned       DATA_W    = INSTR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          cpu_hold
);

`ifdef IMEM_LOADER_CKSUM_EN
    localparam loaderState_e POST_DATA = CKSUM;
`else
    localparam loaderState_e POST_DATA = DONE;
`endif

    loaderState_e      stateQ, nextState;
    logic              inReadyQ;
    logic              busyQ, doneQ, errorQ;
    logic [BYTE_W-1:0] lenHiQ;
    logic [LEN_W-1:0]  lenQ;
    logic [LEN_W-1:0]  wordCntQ;
    logic [ADDR_W-1:0] memAddrQ;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [BYTE_W-1:0] ckQ;
`endif

    logic              accept_c;
    logic              startLoad_c;
    logic              lastWord_c;
    logic              lastByte_c;
    logic [LEN_W-1:0]  lenLo_c;
    logic [DATA_W-1:0] packedWord;
    logic              wordValid;

    assign accept_c    = bus.in_valid && inReadyQ;
    assign startLoad_c = (stateQ == IDLE) && start;
    assign lastWord_c  = (wordCntQ == (lenQ - LEN_W'(1)));
    assign lenLo_c     = {lenHiQ, bus.in_data};

    imem_word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (startLoad_c),
        .byteValid  (accept_c && (stateQ == DATA)),
        .byteIn     (bus.in_data),
        .word       (packedWord),
        .wordValid  (wordValid),
        .lastByte_c (lastByte_c)
    );

    assign bus.in_ready  = inReadyQ;
    assign bus.mem_we    = wordValid;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = packedWord;
    assign busy          = busyQ;
    assign done          = doneQ;
    assign error         = errorQ;
    assign cpu_hold      = busyQ | rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= nextState;
        end
    end

    // Next-state decode from the frame position and the accepted byte.
    always_comb begin
        nextState = stateQ;
        case (stateQ)
            IDLE: begin
                if (start) nextState = LEN_HI;
            end
            LEN_HI: begin
                if (accept_c) nextState = LEN_LO;
            end
            LEN_LO: begin
                if (accept_c) nextState = (lenLo_c == '0) ? POST_DATA : DATA;
            end
            DATA: begin
                if (accept_c && lastByte_c && lastWord_c) nextState = POST_DATA;
            end
            CKSUM: begin
`ifdef IMEM_LOADER_CKSUM_EN
                if (accept_c) nextState = (bus.in_data == ckQ) ? DONE : ERR;
`else
                nextState = IDLE;
`endif
            end
            DONE:    nextState = IDLE;
            ERR:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Registered handshake and status flags, derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            inReadyQ <= 1'b0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            errorQ   <= 1'b0;
        end else begin
            inReadyQ <= acceptsBytes(nextState);
            busyQ    <= acceptsBytes(nextState);
            if (startLoad_c) begin
                doneQ  <= 1'b0;
                errorQ <= 1'b0;
            end
            if (nextState == DONE) doneQ  <= 1'b1;
            if (nextState == ERR)  errorQ <= 1'b1;
        end
    end

    // Frame length, word counter and write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            lenHiQ   <= '0;
            lenQ     <= '0;
            wordCntQ <= '0;
            memAddrQ <= BASE_ADDR;
        end else begin
            if (startLoad_c) begin
                wordCntQ <= '0;
                memAddrQ <= BASE_ADDR;
            end else begin
                if (accept_c && (stateQ == LEN_HI)) lenHiQ <= bus.in_data;
                if (accept_c && (stateQ == LEN_LO)) lenQ <= lenLo_c;
                if (accept_c && (stateQ == DATA) && lastByte_c) wordCntQ <= wordCntQ + LEN_W'(1);
                if (wordValid) memAddrQ <= memAddrQ + ADDR_W'(1);
            end
        end
    end

`ifdef IMEM_LOADER_CKSUM_EN
    // Running XOR of the length and data bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ckQ <= '0;
        end else if (startLoad_c) begin
            ckQ <= '0;
        end else if (accept_c && (stateQ != CKSUM)) begin
            ckQ <= ckQ ^ bus.in_data;
        end
    end
`endif

endmodule
